clk_divider: RTL and testbench



---
 rtl/clk_divider_pkg.sv | 8 +
 rtl/clk_divider_mux.sv | 11 +
 rtl/clk_divider.sv | 93 +++++++++
 tb/tb_clk_divider.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/clk_divider_pkg.sv
// Shared constants for the integer clock divider.
// Phase encoding for the odd-ratio state flag.
package clk_divider_pkg;

    localparam logic PHASE_LOW  = 1'b0;
    localparam logic PHASE_HIGH = 1'b1;

endpackage

// File: rtl/clk_divider_mux.sv
// 2:1 clock select; kept as its own module so a dedicated clock-mux cell can be swapped in.
module clk_divider_mux (
    input  logic clk_a,
    input  logic clk_b,
    input  logic sel,
    output logic clk_out
);

    assign clk_out = sel ? clk_b : clk_a;

endmodule

// File: rtl/clk_divider.sv
// Integer clock divider with runtime ratio: 50% duty for even N, low (N-1)/2 / high (N+1)/2
// for odd N, and a bypass to the reference clock when disabled or N is 0/1.
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int unsigned RATIO_WD = 3
) (
    input  logic                i_ref_clk,
    input  logic                i_rst_n,
    input  logic                i_clk_en,
    input  logic [RATIO_WD-1:0] i_div_ratio,
    output logic                o_div_clk
);

    localparam int unsigned CNT_WD = RATIO_WD - 1;

    logic [CNT_WD-1:0] cnt_q, cnt_d;
    logic              div_q, div_d;
    logic              odd_phase_q, odd_phase_d;

    logic              active;
    logic              bypass;
    logic [CNT_WD-1:0] half;
    logic [CNT_WD-1:0] even_thr;
    logic [CNT_WD-1:0] odd_lo_thr;
    logic [CNT_WD-1:0] odd_hi_thr;

    assign active = i_clk_en && (i_div_ratio != '0) && (i_div_ratio != RATIO_WD'(1));
    assign bypass = !active;

    // For odd N, (N-1)/2 == N>>1 and (N+1)/2 - 1 == N>>1.
    assign half       = i_div_ratio[RATIO_WD-1:1];
    assign even_thr   = half - CNT_WD'(1);
    assign odd_lo_thr = half - CNT_WD'(1);
    assign odd_hi_thr = half;

    // Compares use >= so a ratio decrease can never let cnt run past the threshold and wrap.
    always_comb begin
        cnt_d       = cnt_q;
        div_d       = div_q;
        odd_phase_d = odd_phase_q;
        if (!active) begin
            cnt_d       = '0;
            div_d       = 1'b0;
            odd_phase_d = PHASE_LOW;
        end else if (!i_div_ratio[0]) begin
            if (cnt_q >= even_thr) begin
                cnt_d = '0;
                div_d = ~div_q;
            end else begin
                cnt_d = cnt_q + CNT_WD'(1);
            end
            // Track the output level so a switch to an odd ratio resumes in the right phase.
            odd_phase_d = div_d;
        end else if (odd_phase_q == PHASE_LOW) begin
            if (cnt_q >= odd_lo_thr) begin
                cnt_d       = '0;
                div_d       = 1'b1;
                odd_phase_d = PHASE_HIGH;
            end else begin
                cnt_d = cnt_q + CNT_WD'(1);
            end
        end else begin
            if (cnt_q >= odd_hi_thr) begin
                cnt_d       = '0;
                div_d       = 1'b0;
                odd_phase_d = PHASE_LOW;
            end else begin
                cnt_d = cnt_q + CNT_WD'(1);
            end
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q       <= '0;
            div_q       <= 1'b0;
            odd_phase_q <= PHASE_LOW;
        end else begin
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            odd_phase_q <= odd_phase_d;
        end
    end

    clk_divider_mux u_mux (
        .clk_a   (div_q),
        .clk_b   (i_ref_clk),
        .sel     (bypass),
        .clk_out (o_div_clk)
    );

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: bypass checks plus a per-cycle scoreboard of the
// expected divided waveform, sampled 5 ns after each reference rising edge.
`timescale 1ns/1ps
module tb_clk_divider;

    logic       ref_clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic [2:0] div_ratio;
    logic       div_clk;

    logic       sb_q[$];
    logic       sb_exp;
    string      cur_tag = "idle";
    int         n_tests = 0;
    int         n_fail  = 0;

    always #10 ref_clk = ~ref_clk;

    clk_divider #(
        .RATIO_WD (3)
    ) dut (
        .i_ref_clk   (ref_clk),
        .i_rst_n     (rst_n),
        .i_clk_en    (clk_en),
        .i_div_ratio (div_ratio),
        .o_div_clk   (div_clk)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Scoreboard consumer: one expected level per reference cycle.
    always @(posedge ref_clk) begin
        #5;
        if (sb_q.size() != 0) begin
            sb_exp = sb_q.pop_front();
            check_eq(cur_tag, {31'b0, div_clk}, {31'b0, sb_exp});
        end
    end

    // Level after edge k from a cleared state: low while (k mod N) < floor(N/2), else high.
    task automatic push_seq(input int n, input int start_k, input int count);
        for (int i = 0; i < count; i++) begin
            sb_q.push_back(((start_k + i) % n) >= (n / 2));
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge ref_clk);
        #6;
        check_eq("drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic check_bypass(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge ref_clk); #5;
            check_eq(tag, {31'b0, div_clk}, 32'd1);
            @(negedge ref_clk); #5;
            check_eq(tag, {31'b0, div_clk}, 32'd0);
        end
    endtask

    task automatic start_ratio(input int n, input int count);
        @(negedge ref_clk);
        clk_en = 1'b0;
        @(negedge ref_clk);
        div_ratio = 3'(n);
        clk_en    = 1'b1;
        cur_tag   = $sformatf("div_n%0d", n);
        push_seq(n, 1, count);
        wait_drain();
    endtask

    task automatic wait_high(input string tag);
        for (int i = 0; i < 16 && div_clk !== 1'b1; i++) @(negedge ref_clk);
        check_eq(tag, {31'b0, div_clk}, 32'd1);
    endtask

    task automatic sweep_to(input int n);
        int   gap     = 0;
        int   max_gap = 0;
        logic prev;
        logic found   = 1'b0;
        @(negedge ref_clk);
        div_ratio = 3'(n);
        prev      = div_clk;
        for (int i = 0; i < 4 * n; i++) begin
            @(posedge ref_clk); #5;
            gap++;
            if (!prev && div_clk) begin
                if (gap > max_gap) max_gap = gap;
                gap = 0;
                if (i >= 2 * n) begin
                    found = 1'b1;
                    break;
                end
            end
            prev = div_clk;
        end
        if (gap > max_gap) max_gap = gap;
        check_eq($sformatf("sweep_sync_n%0d", n), {31'b0, found}, 32'd1);
        check_eq($sformatf("sweep_gap_n%0d", n), {31'b0, max_gap <= 14}, 32'd1);
        if (found) begin
            @(negedge ref_clk);
            cur_tag = $sformatf("sweep_n%0d", n);
            push_seq(n, n / 2 + 1, 3 * n);
            wait_drain();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        clk_en    = 1'b0;
        div_ratio = 3'd2;
        #5;
        check_eq("rst_byp_lo", {31'b0, div_clk}, 32'd0);
        #10;
        check_eq("rst_byp_hi", {31'b0, div_clk}, 32'd1);
        rst_n = 1'b1;
        check_bypass("byp_en0", 4);

        @(negedge ref_clk);
        clk_en    = 1'b1;
        div_ratio = 3'd0;
        check_bypass("byp_r0", 3);
        div_ratio = 3'd1;
        check_bypass("byp_r1", 3);

        start_ratio(2, 50);
        start_ratio(3, 50);
        start_ratio(4, 20);

        // Disable while the divided clock is high: output must follow ref immediately.
        wait_high("dis_found_high");
        clk_en = 1'b0;
        #1;
        check_eq("dis_imm", {31'b0, div_clk}, 32'd0);
        check_bypass("dis_byp", 3);
        @(negedge ref_clk);
        clk_en  = 1'b1;
        cur_tag = "reen_n4";
        push_seq(4, 1, 12);
        wait_drain();

        start_ratio(2, 8);
        sweep_to(3);
        sweep_to(4);
        sweep_to(7);

        // Async reset while high, with no clock edge in between.
        start_ratio(5, 10);
        wait_high("arst_found_high");
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_drop", {31'b0, div_clk}, 32'd0);
        @(posedge ref_clk); #5;
        check_eq("arst_hold", {31'b0, div_clk}, 32'd0);
        @(negedge ref_clk); #2;
        rst_n   = 1'b1;
        cur_tag = "arst_rel_n5";
        push_seq(5, 1, 15);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
